// File: rtl/mbox_ebox_port.sv
// MBOX-side responder for the EBOX memory-request handshake, backed by a word store with periodic refresh.
// Optional parity storage and checking is enabled by defining MBOX_PARITY_EN.
module mbox_ebox_port #(
    parameter int unsigned ADDR_BITS      = 10,
    parameter int unsigned READ_LAT       = 3,
    parameter int unsigned REFRESH_PERIOD = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         eboxReq,
    input  logic [13:35] eboxVMA,
    input  logic         eboxRead,
    input  logic         eboxWrite,
    input  logic [0:35]  eboxWrData,
`ifdef MBOX_PARITY_EN
    input  logic         parInject,
`endif
    output logic         cshEBOXT0,
    output logic         cshEBOXRetry,
    output logic         mboxRespIn,
    output logic [0:35]  cacheData,
    output logic [27:35] mboxGateVMA,
    output logic         nxmErr,
    output logic         mbParErr
);

    localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
    localparam int unsigned CW        = $clog2(REFRESH_PERIOD);
    localparam int unsigned WW        = $clog2(READ_LAT + 1);
    localparam int unsigned WAIT_LAST = (READ_LAT > 1) ? READ_LAT - 2 : 0;

    typedef enum logic [2:0] {IDLE, T0, WAIT, RESP, REFRESH} state_t;

    state_t          state;
    logic [CW-1:0]   ref_cnt;
    logic            pending;
    logic            ref_phase;
    logic [WW-1:0]   wcnt;
    logic [13:35]    vma_q;
    logic            rd_q;
    logic            wr_q;
    logic [35:0]     wdata_q;

    logic [35:0]     mem [0:DEPTH-1];

    logic [22:0]          vma_flat;
    logic [ADDR_BITS-1:0] addr;
    logic                 nxm;
    logic                 wrap;
    logic                 refresh_due;
    logic                 accept;
    logic                 go_resp;
    logic [35:0]          rd_word;

    always_comb begin
        vma_flat    = vma_q;
        addr        = vma_flat[ADDR_BITS-1:0];
        nxm         = |(vma_flat >> ADDR_BITS);
        wrap        = (ref_cnt == CW'(REFRESH_PERIOD - 1));
        // a wrap landing on the same edge as a request already counts as pending
        refresh_due = pending || wrap;
        accept      = eboxReq && ((state == IDLE && !refresh_due) ||
                                  (state == REFRESH && ref_phase));
        go_resp     = (state == T0 && READ_LAT == 1) ||
                      (state == WAIT && wcnt == WW'(WAIT_LAST));
        rd_word     = mem[addr];
    end

    assign cshEBOXRetry = eboxReq &&
                          (state == REFRESH || state == WAIT || state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ref_cnt     <= '0;
            pending     <= 1'b0;
            ref_phase   <= 1'b0;
            wcnt        <= '0;
            vma_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            cshEBOXT0   <= 1'b0;
            mboxRespIn  <= 1'b0;
            cacheData   <= '0;
            mboxGateVMA <= '0;
            nxmErr      <= 1'b0;
        end else begin
            ref_cnt    <= wrap ? '0 : ref_cnt + CW'(1);
            if (wrap)
                pending <= 1'b1;
            cshEBOXT0  <= 1'b0;
            mboxRespIn <= 1'b0;
            cacheData  <= '0;
            nxmErr     <= 1'b0;

            case (state)
                IDLE: begin
                    if (refresh_due) begin
                        state     <= REFRESH;
                        pending   <= 1'b0;
                        ref_phase <= 1'b0;
                    end
                end
                REFRESH: begin
                    if (!ref_phase)
                        ref_phase <= 1'b1;
                    else if (!eboxReq)
                        state <= IDLE;
                end
                T0: begin
                    if (READ_LAT > 1) begin
                        state <= WAIT;
                        wcnt  <= '0;
                    end
                end
                WAIT: begin
                    if (!go_resp)
                        wcnt <= wcnt + WW'(1);
                end
                RESP: begin
                    state       <= IDLE;
                    mboxGateVMA <= '0;
                end
                default: state <= IDLE;
            endcase

            // the accept path is shared by IDLE and the final REFRESH cycle
            if (accept) begin
                state       <= T0;
                vma_q       <= eboxVMA;
                rd_q        <= eboxRead;
                wr_q        <= eboxWrite;
                wdata_q     <= eboxWrData;
                cshEBOXT0   <= 1'b1;
                mboxGateVMA <= eboxVMA[27:35];
            end

            if (go_resp) begin
                state      <= RESP;
                mboxRespIn <= 1'b1;
                nxmErr     <= nxm;
                cacheData  <= (rd_q && !nxm) ? rd_word : '0;
            end
        end
    end

    // read and write share the RESP entry edge, so RPW returns the old word
    always_ff @(posedge clk) begin
        if (go_resp && wr_q && !nxm)
            mem[addr] <= wdata_q;
    end

`ifdef MBOX_PARITY_EN
    logic par_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (go_resp && wr_q && !nxm)
            par_mem[addr] <= (^wdata_q) ^ parInject;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mbParErr <= 1'b0;
        else
            mbParErr <= go_resp && rd_q && !nxm && (par_mem[addr] != ^rd_word);
    end
`else
    assign mbParErr = 1'b0;
`endif

endmodule

// File: tb/tb_mbox_ebox_port.sv
// Scoreboard bench for mbox_ebox_port: expected responses are queued at accept and compared at completion.
// Parity scenarios are compiled in when MBOX_PARITY_EN is defined.
module tb_mbox_ebox_port;

    localparam int READ_LAT = 3;

    logic         clk;
    logic         reset;
    logic         eboxReq;
    logic [13:35] eboxVMA;
    logic         eboxRead;
    logic         eboxWrite;
    logic [0:35]  eboxWrData;
`ifdef MBOX_PARITY_EN
    logic         parInject;
`endif
    logic         cshEBOXT0;
    logic         cshEBOXRetry;
    logic         mboxRespIn;
    logic [0:35]  cacheData;
    logic [27:35] mboxGateVMA;
    logic         nxmErr;
    logic         mbParErr;

    mbox_ebox_port #(.ADDR_BITS(10), .READ_LAT(READ_LAT), .REFRESH_PERIOD(64)) dut (
        .clk(clk), .reset(reset), .eboxReq(eboxReq), .eboxVMA(eboxVMA),
        .eboxRead(eboxRead), .eboxWrite(eboxWrite), .eboxWrData(eboxWrData),
`ifdef MBOX_PARITY_EN
        .parInject(parInject),
`endif
        .cshEBOXT0(cshEBOXT0), .cshEBOXRetry(cshEBOXRetry), .mboxRespIn(mboxRespIn),
        .cacheData(cacheData), .mboxGateVMA(mboxGateVMA), .nxmErr(nxmErr), .mbParErr(mbParErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] data;
        logic        nxm;
        logic        par;
        logic [8:0]  gate;
    } exp_t;

    exp_t        sb[$];
    logic [35:0] mem_m [0:1023];
    logic        inj_m [0:1023];
    int          total = 0;
    int          bad   = 0;
    int          ph;

    // refresh counter phase as seen by the bench, counted from reset release
    always @(posedge clk or posedge reset) begin
        if (reset) ph <= 0;
        else       ph <= (ph == 63) ? 0 : ph + 1;
    end

    function automatic void push_exp(input logic rd, input logic wr, input logic [22:0] vma,
                                     input logic [35:0] wd, input logic inj);
        exp_t e;
        logic n;
        logic [9:0] a;
        n = |(vma >> 10);
        a = vma[9:0];
        e.nxm  = n;
        e.gate = vma[8:0];
        e.data = (rd && !n) ? mem_m[a] : 36'd0;
        e.par  = rd && !n && inj_m[a];
        if (wr && !n) begin
            mem_m[a] = wd;
            inj_m[a] = inj;
        end
        sb.push_back(e);
    endfunction

    task automatic wait_window(input int lo, input int hi);
        int n = 0;
        @(negedge clk);
        while (!(ph >= lo && ph <= hi) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL window_wait: phase=%0d required %0d..%0d", ph, lo, hi);
        end
    endtask

    task automatic xfer(input logic rd, input logic wr, input logic [22:0] vma,
                        input logic [35:0] wd, input logic inj,
                        output int t0_lat, output int retries, output int resp_lat,
                        output logic [35:0] o_data, output logic o_nxm, output logic o_par,
                        output logic [8:0] o_gate);
        eboxReq = 1'b1; eboxRead = rd; eboxWrite = wr; eboxVMA = vma; eboxWrData = wd;
`ifdef MBOX_PARITY_EN
        parInject = inj;
`endif
        t0_lat = 0; retries = 0;
        do begin
            @(negedge clk);
            t0_lat++;
            if (cshEBOXRetry) retries++;
        end while (!cshEBOXT0 && t0_lat < 20);
        eboxReq = 1'b0; eboxRead = 1'b0; eboxWrite = 1'b0;
        push_exp(rd, wr, vma, wd, inj);
        resp_lat = 0;
        do begin
            @(negedge clk);
            resp_lat++;
        end while (!mboxRespIn && resp_lat < 20);
        o_data = cacheData; o_nxm = nxmErr; o_par = mbParErr; o_gate = mboxGateVMA;
`ifdef MBOX_PARITY_EN
        parInject = 1'b0;
`endif
    endtask

    task automatic test_reset();
        total++;
        if ({cshEBOXT0, cshEBOXRetry, mboxRespIn, nxmErr, mbParErr} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 00000",
                     {cshEBOXT0, cshEBOXRetry, mboxRespIn, nxmErr, mbParErr});
        end
        total++;
        if (cacheData !== 36'd0 || mboxGateVMA !== 9'd0) begin
            bad++;
            $display("FAIL reset_data: data=%o gate=%o required 0", cacheData, mboxGateVMA);
        end
    endtask

    task automatic test_write_read();
        int t0l, rt, rl; logic [35:0] d; logic n, p; logic [8:0] g; exp_t e;
        wait_window(3, 55);
        xfer(1'b0, 1'b1, 23'd5, 36'o123456701234, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (t0l !== 1) begin bad++; $display("FAIL wr_t0_latency: got %0d required 1", t0l); end
        total++;
        if (rl !== READ_LAT) begin bad++; $display("FAIL wr_resp_latency: got %0d required %0d", rl, READ_LAT); end
        total++;
        if (d !== e.data) begin bad++; $display("FAIL wr_data: got %o required %o", d, e.data); end
        wait_window(3, 55);
        xfer(1'b1, 1'b0, 23'd5, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (d !== e.data) begin bad++; $display("FAIL rd_data: got %o required %o", d, e.data); end
        total++;
        if (g !== 9'o005) begin bad++; $display("FAIL rd_gate: got %o required 005", g); end
        total++;
        if (n !== e.nxm || p !== e.par) begin bad++; $display("FAIL rd_err_flags: got %b%b required %b%b", n, p, e.nxm, e.par); end
        @(negedge clk);
        total++;
        if (mboxRespIn !== 1'b0 || cacheData !== 36'd0) begin
            bad++;
            $display("FAIL resp_pulse_end: resp=%b data=%o required 0/0", mboxRespIn, cacheData);
        end
    endtask

    task automatic test_nxm();
        int t0l, rt, rl; logic [35:0] d; logic n, p; logic [8:0] g; exp_t e;
        wait_window(3, 55);
        xfer(1'b0, 1'b1, 23'd0, 36'o707070707070, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        wait_window(3, 55);
        xfer(1'b1, 1'b1, 23'o2000, 36'o111111111111, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (n !== 1'b1 || n !== e.nxm) begin bad++; $display("FAIL nxm_flag: got %b required 1", n); end
        total++;
        if (d !== e.data) begin bad++; $display("FAIL nxm_data: got %o required %o", d, e.data); end
        total++;
        if (rl !== READ_LAT) begin bad++; $display("FAIL nxm_latency: got %0d required %0d", rl, READ_LAT); end
        wait_window(3, 55);
        xfer(1'b1, 1'b0, 23'd0, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (d !== e.data || n !== 1'b0) begin bad++; $display("FAIL nxm_no_store: got %o nxm=%b required %o nxm=0", d, n, e.data); end
    endtask

    task automatic test_rpw();
        int t0l, rt, rl; logic [35:0] d; logic n, p; logic [8:0] g; exp_t e;
        wait_window(3, 55);
        xfer(1'b0, 1'b1, 23'd7, 36'd1, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        wait_window(3, 55);
        xfer(1'b1, 1'b1, 23'd7, 36'd2, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (d !== e.data) begin bad++; $display("FAIL rpw_old_data: got %o required %o", d, e.data); end
        wait_window(3, 55);
        xfer(1'b1, 1'b0, 23'd7, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (d !== e.data) begin bad++; $display("FAIL rpw_new_data: got %o required %o", d, e.data); end
    endtask

    task automatic test_no_qual();
        int t0l, rt, rl; logic [35:0] d; logic n, p; logic [8:0] g; exp_t e;
        wait_window(3, 55);
        xfer(1'b0, 1'b0, 23'd5, 36'o555555555555, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (d !== e.data || rl !== READ_LAT) begin bad++; $display("FAIL noqual_resp: got %o lat=%0d required %o lat=%0d", d, rl, e.data, READ_LAT); end
        wait_window(3, 55);
        xfer(1'b1, 1'b0, 23'd5, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (d !== e.data) begin bad++; $display("FAIL noqual_no_store: got %o required %o", d, e.data); end
    endtask

    task automatic test_refresh_collision();
        int t0l, rt, rl, k; logic [35:0] d; logic n, p; logic [8:0] g; exp_t e;
        k = 0;
        @(negedge clk);
        while (ph != 63 && k < 200) begin @(negedge clk); k++; end
        xfer(1'b1, 1'b0, 23'd5, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (rt !== 2) begin bad++; $display("FAIL refresh_retries: got %0d required 2", rt); end
        total++;
        if (t0l !== 3) begin bad++; $display("FAIL refresh_t0_latency: got %0d required 3", t0l); end
        total++;
        if (d !== e.data) begin bad++; $display("FAIL refresh_data: got %o required %o", d, e.data); end
    endtask

    task automatic test_back_to_back();
        int t0l, rt, rl, k, t0a, t0b, nresp, retries; logic [35:0] d; logic n, p; logic [8:0] g; exp_t e;
        wait_window(3, 55);
        xfer(1'b0, 1'b1, 23'd10, 36'o111122223333, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        wait_window(3, 40);
        eboxReq = 1'b1; eboxRead = 1'b1; eboxWrite = 1'b0; eboxVMA = 23'd10; eboxWrData = '0;
        k = 0; t0a = -1; t0b = -1; nresp = 0; retries = 0;
        while (nresp < 2 && k < 40) begin
            @(negedge clk);
            k++;
            if (cshEBOXRetry) retries++;
            if (cshEBOXT0) begin
                if (t0a < 0) begin
                    t0a = k;
                    push_exp(1'b1, 1'b0, 23'd10, 36'd0, 1'b0);
                    eboxRead = 1'b0; eboxWrite = 1'b1; eboxVMA = 23'd11; eboxWrData = 36'o444455556666;
                end else begin
                    t0b = k;
                    push_exp(1'b0, 1'b1, 23'd11, 36'o444455556666, 1'b0);
                    eboxReq = 1'b0; eboxWrite = 1'b0;
                end
            end
            if (mboxRespIn) begin
                nresp++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected_resp: got response required none");
                end else begin
                    e = sb.pop_front();
                    if (cacheData !== e.data || mboxGateVMA !== e.gate) begin
                        bad++;
                        $display("FAIL b2b_resp: got %o/%o required %o/%o", cacheData, mboxGateVMA, e.data, e.gate);
                    end
                end
            end
        end
        eboxReq = 1'b0;
        total++;
        if (nresp !== 2) begin bad++; $display("FAIL b2b_count: got %0d required 2", nresp); end
        total++;
        if (t0b - t0a !== READ_LAT + 2) begin bad++; $display("FAIL b2b_spacing: got %0d required %0d", t0b - t0a, READ_LAT + 2); end
        total++;
        if (retries !== READ_LAT) begin bad++; $display("FAIL b2b_retries: got %0d required %0d", retries, READ_LAT); end
        wait_window(3, 55);
        xfer(1'b1, 1'b0, 23'd11, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (d !== e.data) begin bad++; $display("FAIL b2b_stored: got %o required %o", d, e.data); end
    endtask

    task automatic test_reset_mid();
        int t0l, rt, rl, k, nresp; logic [35:0] d; logic n, p; logic [8:0] g; exp_t e;
        wait_window(3, 50);
        eboxReq = 1'b1; eboxRead = 1'b0; eboxWrite = 1'b1; eboxVMA = 23'd5; eboxWrData = 36'o777000777000;
        k = 0;
        do begin @(negedge clk); k++; end while (!cshEBOXT0 && k < 20);
        eboxReq = 1'b0; eboxWrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({cshEBOXT0, cshEBOXRetry, mboxRespIn, nxmErr, mbParErr} !== 5'b0 ||
            cacheData !== 36'd0 || mboxGateVMA !== 9'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: flags=%b data=%o gate=%o required 0",
                     {cshEBOXT0, cshEBOXRetry, mboxRespIn, nxmErr, mbParErr}, cacheData, mboxGateVMA);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        nresp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mboxRespIn) nresp++;
        end
        total++;
        if (nresp !== 0) begin bad++; $display("FAIL reset_mid_no_resp: got %0d responses required 0", nresp); end
        wait_window(3, 55);
        xfer(1'b1, 1'b0, 23'd5, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (d !== e.data) begin bad++; $display("FAIL reset_mid_data: got %o required %o", d, e.data); end
    endtask

`ifdef MBOX_PARITY_EN
    task automatic test_parity();
        int t0l, rt, rl; logic [35:0] d; logic n, p; logic [8:0] g; exp_t e;
        wait_window(3, 55);
        xfer(1'b0, 1'b1, 23'd3, 36'o246013570123, 1'b1, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        wait_window(3, 55);
        xfer(1'b1, 1'b0, 23'd3, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (p !== 1'b1 || p !== e.par) begin bad++; $display("FAIL par_inject: got %b required 1", p); end
        total++;
        if (d !== e.data) begin bad++; $display("FAIL par_data: got %o required %o", d, e.data); end
        wait_window(3, 55);
        xfer(1'b0, 1'b1, 23'd3, 36'o246013570123, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        wait_window(3, 55);
        xfer(1'b1, 1'b0, 23'd3, 36'd0, 1'b0, t0l, rt, rl, d, n, p, g);
        e = sb.pop_front();
        total++;
        if (p !== 1'b0 || p !== e.par) begin bad++; $display("FAIL par_clean: got %b required 0", p); end
    endtask
`endif

    initial begin
        reset = 1'b1; eboxReq = 1'b0; eboxVMA = '0; eboxRead = 1'b0; eboxWrite = 1'b0; eboxWrData = '0;
`ifdef MBOX_PARITY_EN
        parInject = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) inj_m[i] = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_write_read();
        test_nxm();
        test_rpw();
        test_no_qual();
        test_refresh_collision();
        test_back_to_back();
        test_reset_mid();
`ifdef MBOX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
